// File: rtl/slink_rx_pktbuf.sv
// rtl/slink_rx_pktbuf.sv - dual-clock receive packet FIFO with speculative write and commit/rewind
module slink_rx_pktbuf #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_rd,
    input  logic              rst_rd,
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic              wr_dval,
    input  logic              wr_sop,
    input  logic              wr_eop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_err,
    output logic              wr_drop_pulse,
    output logic [15:0]       wr_drop_cnt,
    input  logic              rd_req,
    output logic              rd_empty,
    output logic              rd_dval,
    output logic [DATA_W+1:0] rd_data
);

    localparam int WW = DATA_W + 2;
    localparam int DEPTH_WORDS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} wr_state_t;

    logic [WW-1:0] r_mem [DEPTH_WORDS];

    wr_state_t       r_state;
    wr_state_t       w_state_n;
    logic [ADDR_W:0] r_wp_spec;
    logic [ADDR_W:0] r_wp_cmt;
    logic [ADDR_W:0] r_wp_gray;
    logic [ADDR_W:0] r_rp_sync [SYNC_STAGES];
    logic            r_drop_pulse;
    logic [15:0]     r_drop_cnt;
    logic [ADDR_W:0] w_spec_n;
    logic [ADDR_W:0] w_cmt_n;
    logic [ADDR_W:0] w_waddr;
    logic [ADDR_W:0] w_rp_ws;
    logic [ADDR_W:0] w_fill_spec;
    logic [ADDR_W:0] w_fill_cmt;
    logic            w_full;
    logic            w_full_cmt;
    logic            w_we;
    logic            w_drop;
    logic            w_start;

    logic [ADDR_W:0] r_rp;
    logic [ADDR_W:0] r_rp_gray;
    logic [ADDR_W:0] r_wp_sync [SYNC_STAGES];
    logic            r_rd_dval;
    logic [WW-1:0]   r_rd_data;
    logic [ADDR_W:0] w_wp_rs;
    logic [ADDR_W:0] w_rp_inc;
    logic            w_rd_empty;
    logic            w_rd_en;

    assign w_rp_ws     = gray2bin(r_rp_sync[SYNC_STAGES-1]);
    assign w_fill_spec = r_wp_spec - w_rp_ws;
    assign w_fill_cmt  = r_wp_cmt - w_rp_ws;
    assign w_full      = (w_fill_spec == DEPTH);
    assign w_full_cmt  = (w_fill_cmt == DEPTH);

    // A new SOP always starts at wp_cmt: any open packet has been rewound by then.
    always_comb begin
        w_state_n = r_state;
        w_spec_n  = r_wp_spec;
        w_cmt_n   = r_wp_cmt;
        w_waddr   = r_wp_spec;
        w_we      = 1'b0;
        w_drop    = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_dval && wr_sop) begin
                    w_start = 1'b1;
                end
            end
            S_RECV: begin
                if (wr_err) begin
                    w_spec_n  = r_wp_cmt;
                    w_drop    = 1'b1;
                    w_state_n = (wr_dval && wr_eop) ? S_IDLE : S_DISCARD;
                end else if (wr_dval && wr_sop) begin
                    w_spec_n = r_wp_cmt;
                    w_drop   = 1'b1;
                    w_start  = 1'b1;
                end else if (wr_dval) begin
                    if (w_full) begin
                        w_spec_n  = r_wp_cmt;
                        w_drop    = 1'b1;
                        w_state_n = wr_eop ? S_IDLE : S_DISCARD;
                    end else begin
                        w_we     = 1'b1;
                        w_spec_n = r_wp_spec + 1'b1;
                        if (wr_eop) begin
                            w_cmt_n   = r_wp_spec + 1'b1;
                            w_state_n = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                if (wr_dval && wr_sop) begin
                    w_start = 1'b1;
                end else if (wr_dval && wr_eop) begin
                    w_state_n = S_IDLE;
                end
            end
        endcase
        if (w_start) begin
            if (wr_err || w_full_cmt) begin
                w_drop    = 1'b1;
                w_state_n = wr_eop ? S_IDLE : S_DISCARD;
            end else begin
                w_we      = 1'b1;
                w_waddr   = r_wp_cmt;
                w_spec_n  = r_wp_cmt + 1'b1;
                if (wr_eop) begin
                    w_cmt_n   = r_wp_cmt + 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_state_n = S_RECV;
                end
            end
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr) begin
        if (!rst_wr) begin
            r_state      <= S_IDLE;
            r_wp_spec    <= '0;
            r_wp_cmt     <= '0;
            r_wp_gray    <= '0;
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_rp_sync[i] <= '0;
            end
        end else begin
            r_state      <= w_state_n;
            r_wp_spec    <= w_spec_n;
            r_wp_cmt     <= w_cmt_n;
            r_wp_gray    <= bin2gray(w_cmt_n);
            r_drop_pulse <= w_drop;
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            r_rp_sync[0] <= r_rp_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_rp_sync[i] <= r_rp_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk_wr) begin
        if (w_we) begin
            r_mem[w_waddr[ADDR_W-1:0]] <= {wr_sop, wr_eop, wr_data};
        end
    end

    assign w_wp_rs    = gray2bin(r_wp_sync[SYNC_STAGES-1]);
    assign w_rd_empty = (r_rp == w_wp_rs);
    assign w_rd_en    = rd_req && !w_rd_empty;
    assign w_rp_inc   = r_rp + 1'b1;

    always_ff @(posedge clk_rd or negedge rst_rd) begin
        if (!rst_rd) begin
            r_rp      <= '0;
            r_rp_gray <= '0;
            r_rd_dval <= 1'b0;
            r_rd_data <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_wp_sync[i] <= '0;
            end
        end else begin
            r_rd_dval <= w_rd_en;
            if (w_rd_en) begin
                r_rp      <= w_rp_inc;
                r_rp_gray <= bin2gray(w_rp_inc);
                r_rd_data <= r_mem[r_rp[ADDR_W-1:0]];
            end
            r_wp_sync[0] <= r_wp_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wp_sync[i] <= r_wp_sync[i-1];
            end
        end
    end

    assign wr_drop_pulse = r_drop_pulse;
    assign wr_drop_cnt   = r_drop_cnt;
    assign rd_empty      = w_rd_empty;
    assign rd_dval       = r_rd_dval;
    assign rd_data       = r_rd_data;

endmodule

// File: tb/tb_slink_rx_pktbuf.sv
// tb/tb_slink_rx_pktbuf.sv - scoreboard bench for slink_rx_pktbuf (ADDR_W=4)
`timescale 1ns/1ps
module tb_slink_rx_pktbuf;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;

    logic              clk_rd = 1'b0;
    logic              clk_wr = 1'b0;
    logic              rst_rd = 1'b0;
    logic              rst_wr = 1'b0;
    logic              wr_dval = 1'b0;
    logic              wr_sop = 1'b0;
    logic              wr_eop = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_err = 1'b0;
    logic              wr_drop_pulse;
    logic [15:0]       wr_drop_cnt;
    logic              rd_req = 1'b0;
    logic              rd_empty;
    logic              rd_dval;
    logic [DATA_W+1:0] rd_data;

    slink_rx_pktbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .clk_rd(clk_rd), .rst_rd(rst_rd), .clk_wr(clk_wr), .rst_wr(rst_wr),
        .wr_dval(wr_dval), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_data(wr_data),
        .wr_err(wr_err), .wr_drop_pulse(wr_drop_pulse), .wr_drop_cnt(wr_drop_cnt),
        .rd_req(rd_req), .rd_empty(rd_empty), .rd_dval(rd_dval), .rd_data(rd_data)
    );

    always #5 clk_wr = ~clk_wr;
    always #3.85 clk_rd = ~clk_rd;

    int n_vec = 0;
    int n_miss = 0;
    int n_pulse = 0;
    int exp_drops = 0;
    logic prev_empty = 1'b1;
    logic [DATA_W+1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_rd) begin
        if (rst_rd) begin
            if (rd_dval) begin
                chk("dval_after_empty", {31'd0, prev_empty}, 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_word: got %0h expected none", rd_data);
                end else begin
                    chk("rd_data", {22'd0, rd_data}, {22'd0, sb.pop_front()});
                end
            end
            prev_empty = rd_empty;
        end else begin
            prev_empty = 1'b1;
        end
    end

    always @(negedge clk_wr) begin
        if (rst_wr && wr_drop_pulse) n_pulse++;
    end

    task automatic clr();
        wr_dval = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) @(negedge clk_wr);
    endtask

    task automatic wr_word(input logic sop, input logic eop, input logic err,
                           input logic [DATA_W-1:0] d, input logic expect_out);
        wr_dval = 1'b1; wr_sop = sop; wr_eop = eop; wr_err = err; wr_data = d;
        if (expect_out) sb.push_back({sop, eop, d});
        @(negedge clk_wr);
    endtask

    task automatic set_rd(input logic v);
        @(negedge clk_rd);
        rd_req = v;
        @(negedge clk_wr);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clk_rd);
            k++;
        end
        chk({name, "_drain"}, {31'd0, sb.size() == 0}, 32'd1);
        repeat (8) @(negedge clk_rd);
        chk({name, "_empty"}, {31'd0, rd_empty}, 32'd1);
        @(negedge clk_wr);
    endtask

    task automatic check_drops(input string name);
        idle(4);
        chk({name, "_drop_cnt"}, {16'd0, wr_drop_cnt}, exp_drops);
        chk({name, "_drop_pulses"}, n_pulse, exp_drops);
    endtask

    task automatic do_reset();
        rst_wr = 1'b0;
        rst_rd = 1'b0;
        clr();
        rd_req = 1'b0;
        repeat (4) @(negedge clk_wr);
        rst_wr = 1'b1;
        @(negedge clk_rd);
        rst_rd = 1'b1;
        @(negedge clk_wr);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        do_reset();
        @(negedge clk_rd);
        chk("rst_empty", {31'd0, rd_empty}, 32'd1);
        chk("rst_dval", {31'd0, rd_dval}, 32'd0);
        chk("rst_data", {22'd0, rd_data}, 32'd0);
        chk("rst_drop_cnt", {16'd0, wr_drop_cnt}, 32'd0);
        @(negedge clk_wr);

        // 4-word packet, reader already requesting
        set_rd(1'b1);
        wr_word(1, 0, 0, 8'h11, 1);
        wr_word(0, 0, 0, 8'h22, 1);
        wr_word(0, 0, 0, 8'h33, 1);
        wr_word(0, 1, 0, 8'h44, 1);
        clr();
        got = 1'b0;
        for (int k = 0; k < SYNC + 2; k++) begin
            @(negedge clk_rd);
            if (!rd_empty) got = 1'b1;
        end
        chk("t1_empty_fall", {31'd0, got}, 32'd1);
        @(negedge clk_wr);
        drain("t1");

        // error on eop, then a clean packet
        wr_word(1, 0, 0, 8'h31, 0);
        wr_word(0, 0, 0, 8'h32, 0);
        wr_word(0, 1, 1, 8'h33, 0);
        wr_word(1, 0, 0, 8'hA0, 1);
        wr_word(0, 1, 0, 8'hA1, 1);
        exp_drops++;
        check_drops("t2");
        drain("t2");

        // missing eop followed by a 1-word packet
        wr_word(1, 0, 0, 8'h01, 0);
        wr_word(0, 0, 0, 8'h02, 0);
        wr_word(1, 1, 0, 8'h05, 1);
        exp_drops++;
        check_drops("t3");
        drain("t3");

        // overflow: 15 committed words unread, next packet dies on its 2nd word
        set_rd(1'b0);
        for (int i = 0; i < 15; i++) begin
            wr_word(i == 0, i == 14, 0, 8'(8'h40 + i), 1);
        end
        wr_word(1, 0, 0, 8'h80, 0);
        wr_word(0, 0, 0, 8'h81, 0);
        exp_drops++;
        check_drops("t4_ovf");
        wr_word(0, 1, 0, 8'h82, 0);
        check_drops("t4_eop");
        set_rd(1'b1);
        drain("t4");

        // wrap: 40 back-to-back 5-word packets with concurrent reads
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 5; i++) begin
                wr_word(i == 0, i == 4, 0, 8'(p * 5 + i), 1);
            end
        end
        check_drops("t5");
        drain("t5");

        // both resets mid-packet with a committed packet still unread
        set_rd(1'b0);
        wr_word(1, 0, 0, 8'hB0, 0);
        wr_word(0, 1, 0, 8'hB1, 0);
        wr_word(1, 0, 0, 8'hB2, 0);
        wr_word(0, 0, 0, 8'hB3, 0);
        do_reset();
        n_pulse = 0;
        exp_drops = 0;
        repeat (6) @(negedge clk_rd);
        chk("t6_empty", {31'd0, rd_empty}, 32'd1);
        chk("t6_dval", {31'd0, rd_dval}, 32'd0);
        chk("t6_data", {22'd0, rd_data}, 32'd0);
        @(negedge clk_wr);
        chk("t6_drop_cnt", {16'd0, wr_drop_cnt}, 32'd0);
        set_rd(1'b1);
        wr_word(1, 0, 0, 8'hC0, 1);
        wr_word(0, 0, 0, 8'hC1, 1);
        wr_word(0, 1, 0, 8'hC2, 1);
        check_drops("t6");
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
